ball_horizontal_position: RTL
=============================

# ball_horizontal_position

Synchronous ball horizontal position and video-window generator for Pong. It consumes the `move` rate signal from the ball speed logic (one step request per line) plus paddle-hit and serve strobes. It maintains the ball's X position and direction, and emits the per-pixel `hball` window to the video mixer. Miss strobes go to the score logic.

## Interface
Parameters:
- `H_TOTAL`, 455: pixel clocks per line; internal beam counter wraps at `H_TOTAL-1`.
- `BALL_W`, 4: ball width in pixels.
- `X_SERVE`, 228: X position loaded on reset and serve.
- `X_MIN`, 16: left miss boundary.
- `X_MAX`, 440: right miss boundary; `X_MAX + BALL_W <= H_TOTAL`.

Ports:
- `clk7`, in, 1: pixel clock; the single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `hreset`, in, 1: one-cycle strobe at line start.
- `move`, in, 1: step request level; sampled only on `hreset` cycles.
- `l_hit`, in, 1: one-cycle strobe on left paddle hit.
- `r_hit`, in, 1: one-cycle strobe on right paddle hit.
- `serve`, in, 1: one-cycle strobe that recentres and activates the ball.
- `serve_dir`, in, 1: direction applied on `serve`; 0 = right, 1 = left.
- `hball`, out, 1: registered ball horizontal window.
- `ball_x`, out, 9: current X position.
- `dir`, out, 1: current direction; 0 = right, 1 = left.
- `active`, out, 1: ball in play.
- `miss_l`, out, 1: one-cycle strobe when the ball exits left.
- `miss_r`, out, 1: one-cycle strobe when the ball exits right.

## Operation
- Beam counter `h` (9 bit):
  - Cleared to 0 on `hreset`.
  - Otherwise increments each clock.
  - Saturating wrap from `H_TOTAL-1` to 0 if `hreset` is late.
- Position register `x` (9 bit). Priority per clock, highest first:
  1. `rst`: x=`X_SERVE`, dir=0, active=0.
  2. `serve`: x=`X_SERVE`, dir=`serve_dir`, active=1. A same-cycle `move` or hit is ignored.
  3. Hits: `l_hit` alone sets dir=0; `r_hit` alone sets dir=1; both together toggle dir. Hits are ignored when active=0.
  4. Step: on `hreset` with `move`=1 and active=1:
     - dir=0: x+1.
     - dir=1: x-1.
     - Hit and step in the same cycle: the step uses the new direction.
- Miss detection, evaluated on the step:
  - Next x < `X_MIN`: x holds, active=0, `miss_l` pulses.
  - Next x > `X_MAX`: x holds, active=0, `miss_r` pulses.
  - x never wraps.
- `hball` = active AND (h >= x) AND (h < x + `BALL_W`). Compute in 10-bit arithmetic, no overflow.
- While active=0: `hball`=0, x frozen, `move` ignored.

## Timing
- Reset values: `hball`=0, `ball_x`=`X_SERVE`, `dir`=0, `active`=0, `miss_l`=0, `miss_r`=0; h=0.
- `hball` is registered: it asserts one clock after h reaches x and lasts exactly `BALL_W` clocks.
- Position/direction updates take effect on the clock edge after the strobe. The new x is used for `hball` on the same line, with one-cycle latency.
- Miss strobes:
  - Assert for exactly one clock, on the cycle after the offending `hreset`.
  - Never repeat until the next serve.
  - `miss_l` and `miss_r` are mutually exclusive.
- `rst` mid-line or mid-flight forces the reset values on the next edge. Any pending miss strobe is cancelled.
- At most one step per line, whatever the `move` pulse width.

## Test plan
- Reset then serve with `serve_dir`=0:
  - After serve: `ball_x`=228, `dir`=0, `active`=1.
  - `hball` high for 4 clocks at h=229..232, counting one-cycle latency.
- `move`=1 held over 10 `hreset`s, dir=0 → `ball_x`=238.
- Then `move`=0 for 5 lines → `ball_x` stays 238.
- `r_hit` strobe, then 3 moving lines → `dir`=1, `ball_x`=235.
- `l_hit` and `r_hit` together → dir toggles.
- `l_hit` and `hreset`/`move` in the same cycle → the step goes right.
- Serve left and move until x=16, then one more moving line:
  - `miss_l` pulses once, `active`=0, `ball_x`=16, `hball` stays 0.
  - Further `move` lines change nothing.
- Mirror at the right edge: x=440, one more moving line → `miss_r` pulse, `active`=0.
- Assert `rst` mid-line while `hball`=1:
  - Next clock: `hball`=0, `ball_x`=228, `active`=0.
  - A `serve` in the same cycle as `rst` has no effect.

Source files
------------

// File: rtl/ball_horizontal_position.sv
// Pong ball horizontal position and video window.
// Tracks the ball X position, direction and in-play state. Steps once per line
// on the hreset strobe, reflects on paddle hits and flags misses at the X limits.
// Also produces the registered per-pixel hball window for the video mixer.
module ball_horizontal_position #(
  parameter int H_TOTAL = 455,
  parameter int BALL_W  = 4,
  parameter int X_SERVE = 228,
  parameter int X_MIN   = 16,
  parameter int X_MAX   = 440
) (
  input  logic       clk7,
  input  logic       rst,
  input  logic       hreset,
  input  logic       move,
  input  logic       l_hit,
  input  logic       r_hit,
  input  logic       serve,
  input  logic       serve_dir,
  output logic       hball,
  output logic [8:0] ball_x,
  output logic       dir,
  output logic       active,
  output logic       miss_l,
  output logic       miss_r
);

  localparam logic [8:0] H_LAST  = 9'(H_TOTAL - 1);
  localparam logic [8:0] X_INIT  = 9'(X_SERVE);
  localparam logic [9:0] X_LO    = 10'(X_MIN);
  localparam logic [9:0] X_HI    = 10'(X_MAX);
  localparam logic [9:0] W_BALL  = 10'(BALL_W);

  logic [8:0] h_q, h_d;
  logic [8:0] x_q, x_d;
  logic       dir_q, dir_d;
  logic       active_q, active_d;
  logic       hball_q, hball_d;
  logic       miss_l_q, miss_l_d;
  logic       miss_r_q, miss_r_d;
  logic       hit_dir;
  logic [9:0] x_ext;

  assign x_ext = {1'b0, x_q};

  // Beam counter: cleared at line start, wraps itself if hreset arrives late.
  always_comb begin
    h_d = h_q + 9'd1;
    if (hreset || h_q == H_LAST) h_d = '0;
  end

  // Position, direction and miss logic. Serve dominates hits and steps; a hit
  // in the same cycle as a step steers that step.
  always_comb begin
    x_d      = x_q;
    dir_d    = dir_q;
    active_d = active_q;
    miss_l_d = 1'b0;
    miss_r_d = 1'b0;
    hit_dir  = dir_q;
    if (serve) begin
      x_d      = X_INIT;
      dir_d    = serve_dir;
      active_d = 1'b1;
    end else if (active_q) begin
      unique case ({l_hit, r_hit})
        2'b10:   hit_dir = 1'b0;
        2'b01:   hit_dir = 1'b1;
        2'b11:   hit_dir = ~dir_q;
        default: hit_dir = dir_q;
      endcase
      dir_d = hit_dir;
      if (hreset && move) begin
        if (hit_dir) begin
          // Next x would fall below X_MIN: freeze x and drop out of play.
          if (x_ext < X_LO + 10'd1) begin
            active_d = 1'b0;
            miss_l_d = 1'b1;
          end else begin
            x_d = x_q - 9'd1;
          end
        end else begin
          if (x_ext + 10'd1 > X_HI) begin
            active_d = 1'b0;
            miss_r_d = 1'b1;
          end else begin
            x_d = x_q + 9'd1;
          end
        end
      end
    end
  end

  // Ball window from the current beam and position, 10-bit so x+W cannot wrap.
  always_comb begin
    hball_d = active_q && ({1'b0, h_q} >= x_ext) && ({1'b0, h_q} < x_ext + W_BALL);
  end

  // State registers with synchronous reset; reset also cancels any miss strobe.
  always_ff @(posedge clk7) begin
    if (rst) begin
      h_q      <= '0;
      x_q      <= X_INIT;
      dir_q    <= 1'b0;
      active_q <= 1'b0;
      hball_q  <= 1'b0;
      miss_l_q <= 1'b0;
      miss_r_q <= 1'b0;
    end else begin
      h_q      <= h_d;
      x_q      <= x_d;
      dir_q    <= dir_d;
      active_q <= active_d;
      hball_q  <= hball_d;
      miss_l_q <= miss_l_d;
      miss_r_q <= miss_r_d;
    end
  end

  assign hball  = hball_q;
  assign ball_x = x_q;
  assign dir    = dir_q;
  assign active = active_q;
  assign miss_l = miss_l_q;
  assign miss_r = miss_r_q;

endmodule
